// File: rtl/osc_fsm_pkg.sv
// Shared definitions for the select-driven toggle FSM and its
// ping-pong (oscillation) detector.
package osc_fsm_pkg;

   // Smallest state width that still forms a meaningful walk.
   localparam int MIN_N_BITS = 32'sd2;

   // Classification of what happens to the oscillation history in a cycle.
   typedef enum logic [1:0] {
      STEP_IDLE     = 2'd0,   // no accepted step, no clear: hold everything
      STEP_FRESH    = 2'd1,   // accepted step that starts a new run
      STEP_REVERSAL = 2'd2,   // accepted step repeating the previous select
      STEP_CLEAR    = 2'd3    // history wipe, possibly with a step applied
   } step_kind_e;

   // Ceiling log2, never below 1 so a select port always has a bit.
   function automatic int clog2(input int value);
      int result;
      result = 32'sd1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 32'sd1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/osc_detect.sv
// Oscillation supervisor: remembers the select of the previous accepted
// step, counts consecutive repeats of it (reversals) with saturation and
// raises a sticky flag once the count reaches the limit.
module osc_detect
   import osc_fsm_pkg::*;
#(
   parameter int SEL_W     = 1,
   parameter int CNT_W     = 4,
   parameter int OSC_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,        // synchronous, active low
   input  logic             step_i,     // a step is being taken this cycle
   input  logic [SEL_W-1:0] sel_i,      // select of that step
   input  logic             clr_i,      // wipe history, count and flag
   output logic [CNT_W-1:0] osc_cnt_o,
   output logic             osc_o
);

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(OSC_LIMIT);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};

   logic             last_valid_q, last_valid_d;
   logic [SEL_W-1:0] last_sel_q,   last_sel_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic             osc_q,        osc_d;

   step_kind_e       kind_s;
   logic [CNT_W-1:0] cnt_inc_s;

   // Decide how this cycle affects the history; a clear always wins so a
   // step taken together with a clear is never counted as a reversal.
   always_comb begin
      kind_s = STEP_IDLE;
      if (clr_i) begin
         kind_s = STEP_CLEAR;
      end else if (step_i) begin
         if (last_valid_q && (sel_i == last_sel_q)) begin
            kind_s = STEP_REVERSAL;
         end else begin
            kind_s = STEP_FRESH;
         end
      end else begin
         kind_s = STEP_IDLE;
      end
   end

   // Saturating increment of the reversal count.
   always_comb begin
      cnt_inc_s = cnt_q;
      if (cnt_q != CNT_MAX) begin
         cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_inc_s = CNT_MAX;
      end
   end

   // Next-state for history, count and sticky oscillation flag.
   always_comb begin
      last_valid_d = last_valid_q;
      last_sel_d   = last_sel_q;
      cnt_d        = cnt_q;
      osc_d        = osc_q;
      case (kind_s)
         STEP_CLEAR: begin
            cnt_d        = CNT_ZERO;
            osc_d        = 1'b0;
            last_valid_d = step_i;
            if (step_i) begin
               last_sel_d = sel_i;
            end else begin
               last_sel_d = last_sel_q;
            end
         end
         STEP_REVERSAL: begin
            cnt_d        = cnt_inc_s;
            osc_d        = osc_q | (cnt_inc_s >= LIMIT_C);
            last_valid_d = 1'b1;
            last_sel_d   = sel_i;
         end
         STEP_FRESH: begin
            // A run break resets the count but the flag stays sticky.
            cnt_d        = CNT_ZERO;
            osc_d        = osc_q;
            last_valid_d = 1'b1;
            last_sel_d   = sel_i;
         end
         STEP_IDLE: begin
            cnt_d        = cnt_q;
            osc_d        = osc_q;
         end
         default: begin
            cnt_d        = cnt_q;
            osc_d        = osc_q;
         end
      endcase
   end

   // History registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_valid_q <= 1'b0;
         last_sel_q   <= SEL_ZERO;
         cnt_q        <= CNT_ZERO;
         osc_q        <= 1'b0;
      end else begin
         last_valid_q <= last_valid_d;
         last_sel_q   <= last_sel_d;
         cnt_q        <= cnt_d;
         osc_q        <= osc_d;
      end
   end

   assign osc_cnt_o = cnt_q;
   assign osc_o     = osc_q;

endmodule

// File: rtl/osc_toggle_fsm.sv
// Select-driven toggle state machine: each accepted step flips one state
// bit; a ping-pong supervisor can freeze stepping once oscillation is seen.
module osc_toggle_fsm
   import osc_fsm_pkg::*;
#(
   parameter  int N_BITS    = 2,
   parameter  int OSC_LIMIT = 4,
   parameter  int CNT_W     = 4,
   localparam int SEL_W     = clog2((N_BITS < MIN_N_BITS) ? MIN_N_BITS : N_BITS)
) (
   input  logic              clk,
   input  logic              rst,            // synchronous, active low
   input  logic              en,
   input  logic [SEL_W-1:0]  a,
   input  logic              freeze_on_osc,
   input  logic              clr_osc,
   output logic [N_BITS-1:0] state,
   output logic [SEL_W-1:0]  y,
   output logic              accept,
   output logic              err,
   output logic              osc,
   output logic [CNT_W-1:0]  osc_cnt,
   output logic              locked
);

   // One extra bit so the range check also works when N_BITS = 2**SEL_W.
   localparam logic [SEL_W:0]    N_BITS_C  = (SEL_W + 1)'(N_BITS);
   localparam logic [N_BITS-1:0] ONE_C     = {{(N_BITS-1){1'b0}}, 1'b1};
   localparam logic [N_BITS-1:0] STATE_RST = {N_BITS{1'b0}};
   localparam logic [SEL_W-1:0]  SEL_ZERO  = {SEL_W{1'b0}};

   logic [N_BITS-1:0] state_q, state_d;
   logic [N_BITS-1:0] toggle_s;
   logic              in_range_s;
   logic              err_s;
   logic              locked_s;
   logic              accept_s;
   logic [SEL_W-1:0]  y_s;
   logic              osc_s;
   logic [CNT_W-1:0]  osc_cnt_s;

   // Step acceptance, error, lock and Mealy echo of the select.
   always_comb begin
      in_range_s = ({1'b0, a} < N_BITS_C);
      err_s      = en & ~in_range_s;
      locked_s   = osc_s & freeze_on_osc;
      // A clear overrides the lock so the step that clears can be taken.
      accept_s   = en & in_range_s & (~locked_s | clr_osc);
      if (accept_s) begin
         y_s = a;
      end else begin
         y_s = SEL_ZERO;
      end
   end

   // Next state: flip the selected bit on an accepted step.
   always_comb begin
      toggle_s = ONE_C << a;
      if (accept_s) begin
         state_d = state_q ^ toggle_s;
      end else begin
         state_d = state_q;
      end
   end

   // State register; reset takes priority over every input.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= STATE_RST;
      end else begin
         state_q <= state_d;
      end
   end

   osc_detect #(
      .SEL_W     (SEL_W),
      .CNT_W     (CNT_W),
      .OSC_LIMIT (OSC_LIMIT)
   ) u_osc_detect (
      .clk       (clk),
      .rst       (rst),
      .step_i    (accept_s),
      .sel_i     (a),
      .clr_i     (clr_osc),
      .osc_cnt_o (osc_cnt_s),
      .osc_o     (osc_s)
   );

   assign state   = state_q;
   assign y       = y_s;
   assign accept  = accept_s;
   assign err     = err_s;
   assign osc     = osc_s;
   assign osc_cnt = osc_cnt_s;
   assign locked  = locked_s;

endmodule

// File: tb/tb_osc_toggle_fsm.sv
// Scoreboard bench for osc_toggle_fsm: a 2-bit instance (limit 3) and a
// 3-bit instance for the out-of-range select case.
module tb_osc_toggle_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 2-bit instance
   logic       rst2, en2, frz2, clr2;
   logic [0:0] a2, y2;
   logic [1:0] state2;
   logic       acc2, err2, osc2, lock2;
   logic [3:0] cnt2;

   // 3-bit instance
   logic       rst3, en3, frz3, clr3;
   logic [1:0] a3, y3;
   logic [2:0] state3;
   logic       acc3, err3, osc3, lock3;
   logic [3:0] cnt3;

   osc_toggle_fsm #(.N_BITS(2), .OSC_LIMIT(3), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .a(a2), .freeze_on_osc(frz2),
      .clr_osc(clr2), .state(state2), .y(y2), .accept(acc2), .err(err2),
      .osc(osc2), .osc_cnt(cnt2), .locked(lock2));

   osc_toggle_fsm #(.N_BITS(3), .OSC_LIMIT(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst3), .en(en3), .a(a3), .freeze_on_osc(frz3),
      .clr_osc(clr3), .state(state3), .y(y3), .accept(acc3), .err(err3),
      .osc(osc3), .osc_cnt(cnt3), .locked(lock3));

   typedef struct {
      int         dut;
      logic [2:0] st;
      logic       osc;
      logic [3:0] cnt;
      logic [1:0] y;
      logic       acc;
      logic       err;
      logic       lock;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: pop one expectation per cycle and compare away from the edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.dut == 2) begin
            chk({e.name, ".state"},  int'(state2), int'(e.st));
            chk({e.name, ".osc"},    int'(osc2),   int'(e.osc));
            chk({e.name, ".cnt"},    int'(cnt2),   int'(e.cnt));
            chk({e.name, ".y"},      int'(y2),     int'(e.y));
            chk({e.name, ".accept"}, int'(acc2),   int'(e.acc));
            chk({e.name, ".err"},    int'(err2),   int'(e.err));
            chk({e.name, ".locked"}, int'(lock2),  int'(e.lock));
         end else begin
            chk({e.name, ".state"},  int'(state3), int'(e.st));
            chk({e.name, ".osc"},    int'(osc3),   int'(e.osc));
            chk({e.name, ".cnt"},    int'(cnt3),   int'(e.cnt));
            chk({e.name, ".y"},      int'(y3),     int'(e.y));
            chk({e.name, ".accept"}, int'(acc3),   int'(e.acc));
            chk({e.name, ".err"},    int'(err3),   int'(e.err));
            chk({e.name, ".locked"}, int'(lock3),  int'(e.lock));
         end
      end
   end

   // Drive one cycle on one instance (other idles); expectations are the
   // outputs seen during this cycle, registers reflecting earlier edges.
   task automatic drive(input int dut, input logic rn, input logic en,
                        input logic [1:0] a, input logic frz, input logic clr,
                        input logic [2:0] e_st, input logic e_osc,
                        input logic [3:0] e_cnt, input logic [1:0] e_y,
                        input logic e_acc, input logic e_err,
                        input logic e_lock, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      rst2 = 1'b1; en2 = 1'b0; a2 = 1'b0; frz2 = 1'b0; clr2 = 1'b0;
      rst3 = 1'b1; en3 = 1'b0; a3 = 2'd0; frz3 = 1'b0; clr3 = 1'b0;
      if (dut == 2) begin
         rst2 = rn; en2 = en; a2 = a[0]; frz2 = frz; clr2 = clr;
      end else begin
         rst3 = rn; en3 = en; a3 = a; frz3 = frz; clr3 = clr;
      end
      if (rn) begin
         e.dut = dut; e.st = e_st; e.osc = e_osc; e.cnt = e_cnt; e.y = e_y;
         e.acc = e_acc; e.err = e_err; e.lock = e_lock; e.name = name;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      // Scenario 1: reset both instances with random inputs.
      rst2 = 1'b0; en2 = 1'($urandom); a2 = 1'($urandom);
      frz2 = 1'($urandom); clr2 = 1'($urandom);
      rst3 = 1'b0; en3 = 1'($urandom); a3 = 2'($urandom);
      frz3 = 1'($urandom); clr3 = 1'($urandom);
      @(posedge clk);

      //     dut rn en a  frz clr  st osc cnt y  acc err lck
      // Scenario 2: walk 0,1,0,1
      drive(2, 1, 1, 0, 0, 0,   0, 0, 0,  0, 1,  0,  0, "walk0");
      drive(2, 1, 1, 1, 0, 0,   1, 0, 0,  1, 1,  0,  0, "walk1");
      drive(2, 1, 1, 0, 0, 0,   3, 0, 0,  0, 1,  0,  0, "walk2");
      drive(2, 1, 1, 1, 0, 0,   2, 0, 0,  1, 1,  0,  0, "walk3");
      // Scenario 3: a=0 four times with an idle gap
      drive(2, 1, 1, 0, 0, 0,   0, 0, 0,  0, 1,  0,  0, "pp0");
      drive(2, 1, 1, 0, 0, 0,   1, 0, 0,  0, 1,  0,  0, "pp1");
      drive(2, 1, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0,  0, "ppidle");
      drive(2, 1, 1, 0, 0, 0,   0, 0, 1,  0, 1,  0,  0, "pp2");
      drive(2, 1, 1, 0, 0, 0,   1, 0, 2,  0, 1,  0,  0, "pp3");
      // Scenario 4: lock, clear-with-step, reversal counting resumes
      drive(2, 1, 1, 1, 1, 0,   0, 1, 3,  0, 0,  0,  1, "locked");
      drive(2, 1, 1, 1, 1, 1,   0, 1, 3,  1, 1,  0,  1, "clrstep");
      drive(2, 1, 1, 1, 1, 0,   2, 0, 0,  1, 1,  0,  0, "afterclr");
      drive(2, 1, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0,  0, "rev1");
      // Scenario 6: reach count 2, reset mid-run
      drive(2, 1, 1, 1, 0, 0,   0, 0, 1,  1, 1,  0,  0, "prerst");
      drive(2, 1, 0, 0, 0, 0,   2, 0, 2,  0, 0,  0,  0, "cnt2");
      drive(2, 0, 1, 1, 0, 0,   0, 0, 0,  0, 0,  0,  0, "rstcyc");
      drive(2, 1, 1, 1, 0, 0,   0, 0, 0,  1, 1,  0,  0, "postrst");
      drive(2, 1, 0, 0, 0, 0,   2, 0, 0,  0, 0,  0,  0, "norev");
      // Sticky osc across a run break, then clear without a step
      drive(2, 1, 1, 1, 0, 0,   2, 0, 0,  1, 1,  0,  0, "s0");
      drive(2, 1, 1, 1, 0, 0,   0, 0, 1,  1, 1,  0,  0, "s1");
      drive(2, 1, 1, 1, 0, 0,   2, 0, 2,  1, 1,  0,  0, "s2");
      drive(2, 1, 1, 0, 0, 0,   0, 1, 3,  0, 1,  0,  0, "break");
      drive(2, 1, 0, 0, 0, 1,   1, 1, 0,  0, 0,  0,  0, "clronly");
      drive(2, 1, 1, 0, 0, 0,   1, 0, 0,  0, 1,  0,  0, "fresh");
      drive(2, 1, 0, 0, 0, 0,   0, 0, 0,  0, 0,  0,  0, "fresh_chk");
      // Scenario 5: 3-bit instance, out-of-range select
      drive(3, 1, 1, 1, 0, 0,   0, 0, 0,  1, 1,  0,  0, "n3a1");
      drive(3, 1, 1, 3, 0, 0,   2, 0, 0,  0, 0,  1,  0, "n3err");
      drive(3, 1, 1, 1, 0, 0,   2, 0, 0,  1, 1,  0,  0, "n3rev");
      drive(3, 1, 1, 2, 0, 0,   0, 0, 1,  2, 1,  0,  0, "n3a2");
      drive(3, 1, 0, 3, 0, 0,   4, 0, 0,  0, 0,  0,  0, "n3idle");

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() > 0) @(negedge clk);
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/osc_toggle_fsm.md
# osc_toggle_fsm

Parametrised toggle state machine with N_BITS state bits. Each accepted step flips one state bit, chosen by the select input. The block also detects oscillation: a run of consecutive steps that each flip the same bit as the step before, bouncing between two states. It can freeze itself once oscillation is detected. It is the multi-bit successor of the 4-state, single-input oscillating FSM, and sits as a control/sequencing leaf wherever a select-driven state walk with ping-pong supervision is needed.

## Interface
Parameters:
- N_BITS, 2: state width; must be ≥ 2. Derived SEL_W = clog2(N_BITS).
- OSC_LIMIT, 4: consecutive reversals that raise osc; must be in 1 .. 2^CNT_W−1.
- CNT_W, 4: width of the reversal counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  step request this cycle.
- a  in  SEL_W  index of the state bit to toggle.
- freeze_on_osc  in  1  while 1 and osc=1, steps are refused.
- clr_osc  in  1  clears oscillation history, osc and lock.
- state  out  N_BITS  registered state.
- y  out  SEL_W  Mealy output: equals a when accept=1, else 0.
- accept  out  1  combinational: step taken this cycle.
- err  out  1  combinational: en=1 and a ≥ N_BITS.
- osc  out  1  registered oscillation flag.
- osc_cnt  out  CNT_W  registered consecutive-reversal count.
- locked  out  1  combinational: osc & freeze_on_osc.

## Operation
- Internal history registers: last_valid (1 bit) and last_sel (SEL_W bits).
- accept = en & (a < N_BITS) & (~locked | clr_osc).
- On an accepted step: state ← state ^ (1 << a), last_sel ← a, last_valid ← 1.
- A step is a reversal when last_valid=1 and a == last_sel.
  - Reversal: osc_cnt ← osc_cnt + 1, saturating at 2^CNT_W−1.
  - Accepted non-reversal: osc_cnt ← 0.
- osc ← (next osc_cnt ≥ OSC_LIMIT). osc is sticky until clr_osc or reset; osc_cnt continues to saturate while osc=1.
- Cycles with en=0 leave everything unchanged, so idle cycles do not break a run.
- Refused steps (locked or err) change neither state nor history.
- clr_osc=1 without a step: osc_cnt←0, osc←0, last_valid←0.
- clr_osc=1 with a valid step: the step is applied even if locked. osc_cnt←0, osc←0, last_valid←1, last_sel←a. The step is never counted as a reversal.
- For N_BITS=2, a=0 toggles bit0 and a=1 toggles bit1. This gives the same transitions as the legacy 4-state FSM: s0–s1 and s2–s3 on A=0, s0–s2 and s1–s3 on A=1. y echoes the select.
- err is informational only: no state change, no history change.

## Timing
- Reset (rst=0 at an edge) has priority over all inputs. After the edge: state=0, osc=0, osc_cnt=0, last_valid=0, last_sel=0. Consequently locked=0.
- Reset mid-run discards all history; the first step after reset is never a reversal.
- accept, err, y and locked are combinational from inputs and current registers, in the same cycle.
- state, osc_cnt and osc update at the edge ending an accept cycle: 1-cycle latency.
- osc rises on the same edge on which osc_cnt reaches OSC_LIMIT. locked follows combinationally in the next cycle.
- With N_BITS a power of two, err is constant 0.

## Structure
- Package osc_fsm_pkg: clog2 function for SEL_W, and parameter-check constants (MIN_N_BITS=2).
- One sub-module, osc_detect: holds last_valid, last_sel, osc_cnt and osc. Inputs: step, sel, clr. Output: osc_cnt, osc.
- The top level holds the state register, the accept/err/y/locked logic and reset priority.

## Test plan
All scenarios use N_BITS=2, OSC_LIMIT=3, CNT_W=4 unless stated.
1. rst=0 for one edge with random inputs -> state=0, osc=0, osc_cnt=0, locked=0.
2. en=1, a sequence 0,1,0,1 -> state 1,3,2,0 after each edge. y equals a each cycle, osc_cnt stays 0.
3. en=1, a=0 for four cycles -> state 1,0,1,0; osc_cnt 0,1,2,3; osc=1 after the 4th edge. Insert an en=0 cycle between steps 2 and 3 -> same result.
4. After scenario 3 with freeze_on_osc=1: a=1 -> locked=1, accept=0, state stays 0. Then clr_osc=1 with a=1 -> state=2, osc=0, osc_cnt=0. A following a=1 step counts as reversal 1.
5. N_BITS=3: a=3 with en=1 -> err=1, accept=0, y=0, state and osc_cnt unchanged. The next a=last_sel step still counts as a reversal.
6. Drive ping-pong to osc_cnt=2, then rst=0 for one edge -> all outputs 0. The next step with the same a gives osc_cnt=0.
